// File: rtl/meas_scan_sched.sv
// meas_scan_sched: walks a latched channel mask and routes one channel at a time into a
// single period/duty measurement engine. For each selected channel it lets the engine's
// synchroniser settle, arms one measurement, waits for the finish pulse or a timeout,
// and publishes a tagged result on the res_* stream.
//
// Optional build macro: MEAS_SCAN_RESBANK_EN adds a per-channel result bank with a
// combinational read port (rd_*). Without it only the res_* stream exists.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                1-cycle scan request (ignored while scan_busy_o)
//   stop_i                 level, aborts the scan
//   continuous_i           restart the scan after the last channel
//   ch_mask_i              channels to measure, latched on an accepted start
//   sig_bus_i              raw channel inputs
//   meas_sig_o             muxed channel to the engine
//   meas_enable_o          1-cycle arm pulse to the engine
//   meas_rst_no            engine abort, active-low
//   meas_busy_i, meas_finish_i, meas_freq_i/duty_i/high_i/low_i   engine status/results
//   scan_busy_o, scan_done_o                                      scan status
//   res_valid_o, res_ch_o, res_timeout_o, res_freq_o/duty_o/high_o/low_o   result stream
//   rd_addr_i, rd_freq_o/duty_o/high_o/low_o, rd_timeout_o, rd_fresh_o   (bank only)
module meas_scan_sched #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 2_200_000,
  parameter int unsigned ABORT_CYC   = 2,
  localparam int unsigned ChW        = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
`ifdef MEAS_SCAN_RESBANK_EN
  input  logic [ChW-1:0]    rd_addr_i,
  output logic [25:0]       rd_freq_o,
  output logic [7:0]        rd_duty_o,
  output logic [19:0]       rd_high_o,
  output logic [19:0]       rd_low_o,
  output logic              rd_timeout_o,
  output logic              rd_fresh_o,
`endif
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              continuous_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  input  logic [NUM_CH-1:0] sig_bus_i,
  output logic              meas_sig_o,
  output logic              meas_enable_o,
  output logic              meas_rst_no,
  input  logic              meas_busy_i,
  input  logic              meas_finish_i,
  input  logic [25:0]       meas_freq_i,
  input  logic [7:0]        meas_duty_i,
  input  logic [19:0]       meas_high_i,
  input  logic [19:0]       meas_low_i,
  output logic              scan_busy_o,
  output logic              scan_done_o,
  output logic              res_valid_o,
  output logic [ChW-1:0]    res_ch_o,
  output logic              res_timeout_o,
  output logic [25:0]       res_freq_o,
  output logic [7:0]        res_duty_o,
  output logic [19:0]       res_high_o,
  output logic [19:0]       res_low_o
);

  // One shared counter serves settle, timeout and abort; size it for the largest.
  localparam int unsigned CntMax =
      (TIMEOUT_CYC > SETTLE_CYC) ?
      ((TIMEOUT_CYC > ABORT_CYC) ? TIMEOUT_CYC : ABORT_CYC) :
      ((SETTLE_CYC > ABORT_CYC) ? SETTLE_CYC : ABORT_CYC);
  localparam int unsigned CntW = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYC - 1);
  // Compared before the increment, so the abort is entered as the count reaches
  // TIMEOUT_CYC-1, i.e. TIMEOUT_CYC cycles after the arm pulse.
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 2);
  localparam logic [CntW-1:0] AbortLast   = CntW'(ABORT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle, StSelect, StArm, StWait, StCapture, StAbort, StNext
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  // Search pointer is one bit wider than the channel index so "past the last channel"
  // is representable without wrapping back to 0.
  logic [ChW:0]      ptr_q, ptr_d;
  logic [ChW-1:0]    ch_q, ch_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic              rv_q, rv_d;
  logic [ChW-1:0]    res_ch_q, res_ch_d;
  logic              res_to_q, res_to_d;
  logic [25:0]       res_freq_q, res_freq_d;
  logic [7:0]        res_duty_q, res_duty_d;
  logic [19:0]       res_high_q, res_high_d;
  logic [19:0]       res_low_q, res_low_d;

  // Lowest set mask bit at or above the search pointer.
  logic           hit;
  logic [ChW-1:0] hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && ((ChW + 1)'(i) >= ptr_q)) begin
        hit     = 1'b1;
        hit_idx = ChW'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    ptr_d      = ptr_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    done_d     = 1'b0;
    rv_d       = 1'b0;
    res_ch_d   = res_ch_q;
    res_to_d   = res_to_q;
    res_freq_d = res_freq_q;
    res_duty_d = res_duty_q;
    res_high_d = res_high_q;
    res_low_d  = res_low_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mask_d  = ch_mask_i;
          ptr_d   = '0;
          state_d = StNext;
        end
      end
      StNext: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (hit) begin
          ch_d    = hit_idx;
          ptr_d   = {1'b0, hit_idx};
          cnt_d   = '0;
          state_d = StSelect;
        end else begin
          done_d = 1'b1;
          if (continuous_i) begin
            ptr_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StSelect: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (cnt_q == SettleLast) begin
          state_d = StArm;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StArm: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (!meas_busy_i) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (stop_i) begin
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = StAbort;
        end else if (meas_finish_i) begin
          state_d = StCapture;
        end else if (cnt_q == TimeoutLast) begin
          cnt_d   = '0;
          pend_d  = 1'b1;
          state_d = StAbort;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCapture: begin
        // Engine results land one cycle after its finish pulse.
        if (stop_i) begin
          state_d = StIdle;
        end else begin
          rv_d       = 1'b1;
          res_ch_d   = ch_q;
          res_to_d   = 1'b0;
          res_freq_d = meas_freq_i;
          res_duty_d = meas_duty_i;
          res_high_d = meas_high_i;
          res_low_d  = meas_low_i;
          ptr_d      = {1'b0, ch_q} + 1'b1;
          state_d    = StNext;
        end
      end
      StAbort: begin
        // The engine reset always runs its full length; stop only drops the pending
        // timeout result and sends the scan to idle afterwards.
        if (stop_i) begin
          pend_d = 1'b0;
        end
        if (cnt_q == AbortLast) begin
          if (pend_q && !stop_i) begin
            rv_d       = 1'b1;
            res_ch_d   = ch_q;
            res_to_d   = 1'b1;
            res_freq_d = '0;
            res_duty_d = '0;
            res_high_d = '0;
            res_low_d  = '0;
            ptr_d      = {1'b0, ch_q} + 1'b1;
            state_d    = StNext;
          end else begin
            state_d = StIdle;
          end
          pend_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    meas_enable_o = (state_q == StArm) && !meas_busy_i && !stop_i;
    meas_rst_no   = (state_q != StAbort);
    scan_busy_o   = (state_q != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q     <= '0;
      ptr_q      <= '0;
      ch_q       <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      rv_q       <= 1'b0;
      res_ch_q   <= '0;
      res_to_q   <= 1'b0;
      res_freq_q <= '0;
      res_duty_q <= '0;
      res_high_q <= '0;
      res_low_q  <= '0;
    end else begin
      mask_q     <= mask_d;
      ptr_q      <= ptr_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      rv_q       <= rv_d;
      res_ch_q   <= res_ch_d;
      res_to_q   <= res_to_d;
      res_freq_q <= res_freq_d;
      res_duty_q <= res_duty_d;
      res_high_q <= res_high_d;
      res_low_q  <= res_low_d;
    end
  end

  assign meas_sig_o    = sig_bus_i[ch_q];
  assign scan_done_o   = done_q;
  assign res_valid_o   = rv_q;
  assign res_ch_o      = res_ch_q;
  assign res_timeout_o = res_to_q;
  assign res_freq_o    = res_freq_q;
  assign res_duty_o    = res_duty_q;
  assign res_high_o    = res_high_q;
  assign res_low_o     = res_low_q;

`ifdef MEAS_SCAN_RESBANK_EN
  logic [25:0]       bank_freq_q [NUM_CH];
  logic [7:0]        bank_duty_q [NUM_CH];
  logic [19:0]       bank_high_q [NUM_CH];
  logic [19:0]       bank_low_q  [NUM_CH];
  logic [NUM_CH-1:0] bank_to_q;
  logic [NUM_CH-1:0] fresh_q;
  logic              rd_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) begin
        bank_freq_q[i] <= '0;
        bank_duty_q[i] <= '0;
        bank_high_q[i] <= '0;
        bank_low_q[i]  <= '0;
      end
      bank_to_q <= '0;
      fresh_q   <= '0;
    end else begin
      if (state_q == StIdle && start_i) begin
        fresh_q <= '0;
      end
      if (rv_d) begin
        bank_freq_q[ch_q] <= res_freq_d;
        bank_duty_q[ch_q] <= res_duty_d;
        bank_high_q[ch_q] <= res_high_d;
        bank_low_q[ch_q]  <= res_low_d;
        bank_to_q[ch_q]   <= res_to_d;
        fresh_q[ch_q]     <= 1'b1;
      end
    end
  end

  // Guard addresses past NUM_CH when NUM_CH is not a power of two.
  assign rd_ok        = ({1'b0, rd_addr_i} < (ChW + 1)'(NUM_CH));
  assign rd_freq_o    = rd_ok ? bank_freq_q[rd_addr_i] : '0;
  assign rd_duty_o    = rd_ok ? bank_duty_q[rd_addr_i] : '0;
  assign rd_high_o    = rd_ok ? bank_high_q[rd_addr_i] : '0;
  assign rd_low_o     = rd_ok ? bank_low_q[rd_addr_i] : '0;
  assign rd_timeout_o = rd_ok ? bank_to_q[rd_addr_i] : 1'b0;
  assign rd_fresh_o   = rd_ok ? fresh_q[rd_addr_i] : 1'b0;
`endif

endmodule

// File: tb/tb_meas_scan_sched.sv
module tb_meas_scan_sched;
  localparam int unsigned NCH    = 4;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned TMO    = 100;
  localparam int unsigned ABT    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic [3:0]  ch_mask = '0, sig_bus = '0;
  logic        meas_sig, meas_enable, meas_rst_n;
  logic        meas_busy = 1'b0, meas_finish = 1'b0;
  logic [25:0] meas_freq = '0;
  logic [7:0]  meas_duty = '0;
  logic [19:0] meas_high = '0, meas_low = '0;
  logic        scan_busy, scan_done, res_valid, res_timeout;
  logic [1:0]  res_ch;
  logic [25:0] res_freq;
  logic [7:0]  res_duty;
  logic [19:0] res_high, res_low;

  int unsigned n_chk = 0, n_fail = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  meas_scan_sched #(
    .NUM_CH(NCH), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO), .ABORT_CYC(ABT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
    .continuous_i(continuous), .ch_mask_i(ch_mask), .sig_bus_i(sig_bus),
    .meas_sig_o(meas_sig), .meas_enable_o(meas_enable), .meas_rst_no(meas_rst_n),
    .meas_busy_i(meas_busy), .meas_finish_i(meas_finish), .meas_freq_i(meas_freq),
    .meas_duty_i(meas_duty), .meas_high_i(meas_high), .meas_low_i(meas_low),
    .scan_busy_o(scan_busy), .scan_done_o(scan_done), .res_valid_o(res_valid),
    .res_ch_o(res_ch), .res_timeout_o(res_timeout), .res_freq_o(res_freq),
    .res_duty_o(res_duty), .res_high_o(res_high), .res_low_o(res_low)
  );

  typedef struct {
    int unsigned cyc;
    int unsigned ch;
    logic        to;
    logic [25:0] f;
    logic [7:0]  d;
    logic [19:0] h;
    logic [19:0] l;
  } res_t;

  res_t        q_res[$];   // observed results
  res_t        q_eng[$];   // values the engine model produced, with its finish cycle
  int unsigned q_done[$], q_en[$], q_rst[$];
  logic [4:0]  q_sig[$];   // {meas_sig, sig_bus} seen at each arm pulse

  // Engine model knobs
  bit          eng_never = 1'b0;   // never finish
  bit          eng_fixed = 1'b1;   // fixed result values
  int unsigned eng_lat   = 0;      // 0 = random latency
  bit          force_busy = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Observer, sampled mid-cycle
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (res_valid) begin
          r.cyc = cyc; r.ch = int'(res_ch); r.to = res_timeout;
          r.f = res_freq; r.d = res_duty; r.h = res_high; r.l = res_low;
          q_res.push_back(r);
        end
        if (scan_done) q_done.push_back(cyc);
        if (meas_enable) begin
          q_en.push_back(cyc);
          q_sig.push_back({meas_sig, sig_bus});
        end
        if (!meas_rst_n) q_rst.push_back(cyc);
      end
    end
  end

  // Behavioural measurement engine: busy after arm, finish pulse after a latency,
  // junk on the result bus during the finish cycle, real values one cycle later.
  initial begin
    bit          cnting = 1'b0, rpend = 1'b0, ebusy = 1'b0;
    int unsigned ecnt = 0;
    logic        en_s, rn_s;
    res_t        nxt;
    forever begin
      @(negedge clk);
      en_s = meas_enable;
      rn_s = meas_rst_n;
      @(posedge clk);
      #1;
      sig_bus     = 4'($urandom);
      meas_finish = 1'b0;
      if (rpend) begin
        meas_freq = nxt.f; meas_duty = nxt.d; meas_high = nxt.h; meas_low = nxt.l;
        rpend = 1'b0;
      end
      if (!rst_n || !rn_s) begin
        cnting = 1'b0;
        ebusy  = 1'b0;
      end else if (en_s) begin
        cnting = 1'b1;
        ebusy  = 1'b1;
        ecnt   = (eng_lat == 0) ? $urandom_range(60, 1) : eng_lat;
      end else if (cnting && !eng_never) begin
        ecnt--;
        if (ecnt == 0) begin
          meas_finish = 1'b1;
          ebusy  = 1'b0;
          cnting = 1'b0;
          rpend  = 1'b1;
          if (eng_fixed) begin
            nxt.f = 26'd1_000_000; nxt.d = 8'd50; nxt.h = 20'd25; nxt.l = 20'd25;
          end else begin
            nxt.f = 26'($urandom); nxt.d = 8'($urandom_range(100, 0));
            nxt.h = 20'($urandom); nxt.l = 20'($urandom);
          end
          nxt.cyc = cyc; nxt.ch = 0; nxt.to = 1'b0;
          q_eng.push_back(nxt);
          meas_freq = 26'($urandom); meas_duty = 8'($urandom);
          meas_high = 20'($urandom); meas_low = 20'($urandom);
        end
      end
      meas_busy = ebusy | force_busy;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic clr_logs();
    q_res.delete(); q_eng.delete(); q_done.delete(); q_en.delete();
    q_rst.delete(); q_sig.delete();
  endtask

  task automatic pulse_start(input logic [3:0] m, output int unsigned sc);
    @(posedge clk); #1;
    ch_mask = m;
    start = 1'b1;
    sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(budget); i++) begin
      @(negedge clk);
      if (!scan_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (meas_enable !== 1'b0) begin n_fail++; $display("FAIL rst_enable: got %b want 0", meas_enable); end
    n_chk++; if (meas_rst_n !== 1'b1) begin n_fail++; $display("FAIL rst_meas_rst_n: got %b want 1", meas_rst_n); end
    n_chk++; if (scan_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", scan_busy); end
    n_chk++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", scan_done); end
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", res_valid); end
    n_chk++; if ({res_ch, res_timeout, res_freq, res_duty, res_high, res_low} !== '0) begin
      n_fail++; $display("FAIL rst_res: got ch=%0d to=%b f=%0d want all 0", res_ch, res_timeout, res_freq);
    end
    n_chk++; if (meas_sig !== sig_bus[0]) begin n_fail++; $display("FAIL rst_mux: got %b want %b", meas_sig, sig_bus[0]); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Shared reference: the scan visits set mask bits in ascending order, one result each.
  task automatic test_scan(input logic [3:0] m, input bit fixed, input bit wiggle_mask,
                           input string tag);
    int unsigned sc, exp_n;
    int unsigned exp_ch[$];
    bit ok;
    eng_fixed = fixed; eng_never = 1'b0; eng_lat = 0;
    clr_logs();
    for (int i = 0; i < 4; i++) if (m[i]) exp_ch.push_back(i);
    exp_n = exp_ch.size();
    pulse_start(m, sc);
    if (wiggle_mask) ch_mask = ~m;
    wait_idle(2000, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL %s_idle: got busy want idle", tag); end
    n_chk++; if (q_res.size() != exp_n) begin n_fail++; $display("FAIL %s_nres: got %0d want %0d", tag, q_res.size(), exp_n); end
    n_chk++; if (q_en.size() != exp_n) begin n_fail++; $display("FAIL %s_nen: got %0d want %0d", tag, q_en.size(), exp_n); end
    n_chk++; if (q_done.size() != 1) begin n_fail++; $display("FAIL %s_ndone: got %0d want 1", tag, q_done.size()); end
    if (q_en.size() > 0) begin
      n_chk++; if (q_en[0] != sc + 2 + SETTLE) begin n_fail++; $display("FAIL %s_arm_cyc: got %0d want %0d", tag, q_en[0], sc + 2 + SETTLE); end
    end
    for (int i = 0; i < exp_n && i < q_res.size() && i < q_eng.size(); i++) begin
      n_chk++; if (q_res[i].ch != exp_ch[i] || q_res[i].to !== 1'b0) begin
        n_fail++; $display("FAIL %s_ch%0d: got ch=%0d to=%b want ch=%0d to=0", tag, i, q_res[i].ch, q_res[i].to, exp_ch[i]);
      end
      n_chk++; if (q_res[i].f !== q_eng[i].f || q_res[i].d !== q_eng[i].d ||
                   q_res[i].h !== q_eng[i].h || q_res[i].l !== q_eng[i].l) begin
        n_fail++; $display("FAIL %s_val%0d: got f=%0d d=%0d h=%0d l=%0d want f=%0d d=%0d h=%0d l=%0d", tag, i,
          q_res[i].f, q_res[i].d, q_res[i].h, q_res[i].l, q_eng[i].f, q_eng[i].d, q_eng[i].h, q_eng[i].l);
      end
      n_chk++; if (q_res[i].cyc != q_eng[i].cyc + 2) begin
        n_fail++; $display("FAIL %s_lat%0d: got cycle %0d want %0d", tag, i, q_res[i].cyc, q_eng[i].cyc + 2);
      end
    end
    for (int i = 0; i < exp_n && i < q_sig.size(); i++) begin
      logic [4:0] s;
      s = q_sig[i];
      n_chk++; if (s[4] !== s[exp_ch[i]]) begin n_fail++; $display("FAIL %s_mux%0d: got %b want %b", tag, i, s[4], s[exp_ch[i]]); end
    end
  endtask

  task automatic test_basic_scan();
    test_scan(4'b0101, 1'b1, 1'b0, "basic");
    n_chk++; if (scan_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b want 0", scan_busy); end
  endtask

  task automatic test_random_scans();
    for (int k = 0; k < 6; k++) begin
      logic [3:0] m;
      m = 4'($urandom_range(15, 1));
      test_scan(m, 1'b0, 1'b1, "rand");
    end
  endtask

  task automatic test_empty_mask();
    int unsigned sc;
    bit ok;
    clr_logs();
    pulse_start(4'b0000, sc);
    wait_idle(20, ok);
    repeat (3) @(negedge clk);
    n_chk++; if (q_done.size() != 1) begin n_fail++; $display("FAIL empty_ndone: got %0d want 1", q_done.size()); end
    else begin
      n_chk++; if (q_done[0] != sc + 2) begin n_fail++; $display("FAIL empty_done_cyc: got %0d want %0d", q_done[0], sc + 2); end
    end
    n_chk++; if (q_en.size() != 0 || q_res.size() != 0) begin
      n_fail++; $display("FAIL empty_activity: got en=%0d res=%0d want 0/0", q_en.size(), q_res.size());
    end
  endtask

  task automatic test_timeout();
    int unsigned sc;
    bit ok;
    clr_logs();
    eng_never = 1'b1;
    pulse_start(4'b0010, sc);
    wait_idle(1000, ok);
    eng_never = 1'b0;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL tmo_idle: got busy want idle"); end
    n_chk++; if (q_en.size() != 1 || q_rst.size() != ABT) begin
      n_fail++; $display("FAIL tmo_counts: got en=%0d rst=%0d want 1/%0d", q_en.size(), q_rst.size(), ABT);
    end else begin
      n_chk++; if (q_rst[0] != q_en[0] + TMO || q_rst[ABT-1] != q_en[0] + TMO + ABT - 1) begin
        n_fail++; $display("FAIL tmo_abort_cyc: got %0d..%0d want %0d..%0d", q_rst[0], q_rst[ABT-1],
          q_en[0] + TMO, q_en[0] + TMO + ABT - 1);
      end
    end
    n_chk++; if (q_res.size() != 1) begin n_fail++; $display("FAIL tmo_nres: got %0d want 1", q_res.size()); end
    else begin
      n_chk++; if (q_res[0].ch != 1 || q_res[0].to !== 1'b1 || q_res[0].f !== '0 || q_res[0].d !== '0 ||
                   q_res[0].h !== '0 || q_res[0].l !== '0) begin
        n_fail++; $display("FAIL tmo_res: got ch=%0d to=%b f=%0d d=%0d want ch=1 to=1 f=0 d=0", q_res[0].ch,
          q_res[0].to, q_res[0].f, q_res[0].d);
      end
    end
    n_chk++; if (q_done.size() != 1) begin n_fail++; $display("FAIL tmo_ndone: got %0d want 1", q_done.size()); end
  endtask

  // Finish on the last WAIT cycle beats the timeout; one cycle later it does not.
  task automatic test_timeout_edge();
    int unsigned sc;
    bit ok;
    clr_logs();
    eng_fixed = 1'b0; eng_lat = TMO - 2;
    pulse_start(4'b0100, sc);
    wait_idle(1000, ok);
    n_chk++; if (q_res.size() != 1 || q_eng.size() != 1 || q_rst.size() != 0) begin
      n_fail++; $display("FAIL edge_win_counts: got res=%0d fin=%0d rst=%0d want 1/1/0", q_res.size(), q_eng.size(), q_rst.size());
    end else begin
      n_chk++; if (q_res[0].to !== 1'b0 || q_res[0].ch != 2 || q_res[0].f !== q_eng[0].f || q_res[0].cyc != q_eng[0].cyc + 2) begin
        n_fail++; $display("FAIL edge_win_res: got to=%b ch=%0d f=%0d cyc=%0d want to=0 ch=2 f=%0d cyc=%0d", q_res[0].to,
          q_res[0].ch, q_res[0].f, q_res[0].cyc, q_eng[0].f, q_eng[0].cyc + 2);
      end
    end
    clr_logs();
    eng_lat = TMO - 1;
    pulse_start(4'b0100, sc);
    wait_idle(1000, ok);
    n_chk++; if (q_res.size() != 1) begin n_fail++; $display("FAIL edge_late_nres: got %0d want 1", q_res.size()); end
    else begin
      n_chk++; if (q_res[0].to !== 1'b1 || q_res[0].f !== '0) begin
        n_fail++; $display("FAIL edge_late_res: got to=%b f=%0d want to=1 f=0", q_res[0].to, q_res[0].f);
      end
    end
    eng_lat = 0;
  endtask

  task automatic test_busy_hold();
    int unsigned sc;
    bit ok;
    clr_logs();
    force_busy = 1'b1;
    pulse_start(4'b0001, sc);
    repeat (30) @(negedge clk);
    n_chk++; if (q_en.size() != 0 || scan_busy !== 1'b1) begin
      n_fail++; $display("FAIL hold_arm: got en=%0d busy=%b want 0/1", q_en.size(), scan_busy);
    end
    @(posedge clk); #1;
    force_busy = 1'b0;
    wait_idle(500, ok);
    n_chk++; if (q_en.size() != 1 || q_res.size() != 1) begin
      n_fail++; $display("FAIL hold_release: got en=%0d res=%0d want 1/1", q_en.size(), q_res.size());
    end
  endtask

  task automatic test_continuous();
    int unsigned sc;
    bit ok, got3;
    clr_logs();
    continuous = 1'b1;
    got3 = 1'b0;
    pulse_start(4'b1000, sc);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (q_res.size() >= 3) begin got3 = 1'b1; break; end
    end
    @(posedge clk); #1;
    continuous = 1'b0;
    wait_idle(500, ok);
    n_chk++; if (!got3 || !ok) begin n_fail++; $display("FAIL cont_run: got passes3=%b idle=%b want 1/1", got3, ok); end
    n_chk++; if (q_done.size() != q_res.size()) begin
      n_fail++; $display("FAIL cont_done: got done=%0d want %0d", q_done.size(), q_res.size());
    end
    for (int i = 0; i < q_res.size(); i++) begin
      n_chk++; if (q_res[i].ch != 3) begin n_fail++; $display("FAIL cont_ch%0d: got %0d want 3", i, q_res[i].ch); end
    end
  endtask

  task automatic test_stop();
    int unsigned sc, dummy;
    bit ok, armed;
    clr_logs();
    eng_never = 1'b1;
    armed = 1'b0;
    pulse_start(4'b0010, sc);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q_en.size() > 0) begin armed = 1'b1; break; end
    end
    repeat (10) @(negedge clk);
    pulse_start(4'b0001, dummy);   // must be ignored while busy
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_idle(50, ok);
    repeat (5) @(negedge clk);
    eng_never = 1'b0;
    n_chk++; if (!armed || !ok) begin n_fail++; $display("FAIL stop_wait_flow: got armed=%b idle=%b want 1/1", armed, ok); end
    n_chk++; if (q_rst.size() != ABT) begin n_fail++; $display("FAIL stop_wait_abort: got %0d want %0d", q_rst.size(), ABT); end
    n_chk++; if (q_res.size() != 0 || q_done.size() != 0 || q_en.size() != 1) begin
      n_fail++; $display("FAIL stop_wait_quiet: got res=%0d done=%0d en=%0d want 0/0/1", q_res.size(), q_done.size(), q_en.size());
    end
    clr_logs();
    pulse_start(4'b0001, sc);
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_idle(50, ok);
    repeat (10) @(negedge clk);
    n_chk++; if (!ok || q_en.size() != 0 || q_rst.size() != 0 || q_res.size() != 0 || q_done.size() != 0) begin
      n_fail++; $display("FAIL stop_select: got idle=%b en=%0d rst=%0d res=%0d done=%0d want 1/0/0/0/0", ok,
        q_en.size(), q_rst.size(), q_res.size(), q_done.size());
    end
  endtask

  task automatic test_reset_midscan();
    int unsigned sc;
    bit two;
    clr_logs();
    eng_fixed = 1'b1;
    two = 1'b0;
    pulse_start(4'b1111, sc);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (q_en.size() >= 2) begin two = 1'b1; break; end
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if (!two) begin n_fail++; $display("FAIL mid_reach: got en=%0d want 2", q_en.size()); end
    n_chk++; if (scan_busy !== 1'b0 || meas_rst_n !== 1'b1 || meas_enable !== 1'b0 || scan_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_ctrl: got busy=%b rstn=%b en=%b done=%b want 0/1/0/0", scan_busy, meas_rst_n, meas_enable, scan_done);
    end
    n_chk++; if (res_valid !== 1'b0 || res_freq !== '0 || res_ch !== '0) begin
      n_fail++; $display("FAIL mid_res: got v=%b f=%0d ch=%0d want 0/0/0", res_valid, res_freq, res_ch);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_chk++; if (q_en.size() != 2 || scan_busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_after: got en=%0d busy=%b want 2/0", q_en.size(), scan_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_empty_mask();
    test_random_scans();
    test_timeout();
    test_timeout_edge();
    test_busy_hold();
    test_continuous();
    test_stop();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
